// File: rtl/qkv_line_fetcher_pkg.sv
// Shared hyper-parameters and FSM encodings for the Q/K/V line fetcher.
// Imported by qkv_fetch_fifo and qkv_line_fetcher.
package qkv_line_fetcher_pkg;

    localparam int QKV_LINE_W     = 128;
    localparam int QKV_ADDR_W     = 10;
    localparam int QKV_NUM_LINES  = 768;
    localparam int QKV_FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_STREAM   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/qkv_fetch_fifo.sv
// Two-entry register FIFO holding matched {Q,K,V,idx} entries.
// Ports: s_clk, s_rst (async, active-high), push/din, pop, count, head.
module qkv_fetch_fifo
    import qkv_line_fetcher_pkg::*;
#(
    parameter int W = 3 * QKV_LINE_W + QKV_ADDR_W
) (
    input  logic         s_clk,
    input  logic         s_rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;

    // mem0 is always the head; a pop shifts mem1 forward.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) mem0 <= din;
                    else               mem1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        mem0 <= mem1;
                        mem1 <= din;
                    end else begin
                        mem0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = mem0;

endmodule

// File: rtl/qkv_line_fetcher.sv
// Walks the Q/K/V RAMs in lockstep and streams matched lines downstream.
// Ports: s_clk, s_rst, i_start, i_ram_ready, o_rd_addr, o_rd_en,
//   i_q/k/v_line, o_valid, i_ready, o_q/k/v_line, o_line_idx, o_last,
//   o_busy, o_done; o_stall_cnt only when QKV_FETCH_PERF_EN is defined.
module qkv_line_fetcher
    import qkv_line_fetcher_pkg::*;
#(
    parameter int LINE_W     = QKV_LINE_W,
    parameter int ADDR_W     = QKV_ADDR_W,
    parameter int NUM_LINES  = QKV_NUM_LINES,
    parameter int FIFO_DEPTH = QKV_FIFO_DEPTH
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              i_start,
    input  logic              i_ram_ready,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_en,
    input  logic [LINE_W-1:0] i_q_line,
    input  logic [LINE_W-1:0] i_k_line,
    input  logic [LINE_W-1:0] i_v_line,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [LINE_W-1:0] o_q_line,
    output logic [LINE_W-1:0] o_k_line,
    output logic [LINE_W-1:0] o_v_line,
    output logic [ADDR_W-1:0] o_line_idx,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
`ifdef QKV_FETCH_PERF_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);

    localparam int EW = 3 * LINE_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LINES - 1);
    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    fetch_state_t state, state_nx;

    logic [ADDR_W-1:0] addr;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_idx;
    logic [1:0]        fifo_count;
    logic [EW-1:0]     head;
    logic              pop;
    logic              issue;
    logic              accept;
    logic [2:0]        credit_use;

    assign o_valid = (fifo_count != 2'd0);
    assign pop     = o_valid & i_ready;
    assign accept  = (state == ST_IDLE) & i_start;

    // Slots committed for the end of this cycle: buffered + the read
    // returning now - the line leaving now.
    assign credit_use = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (state == ST_STREAM) && (credit_use < DEPTH);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:     if (i_start) state_nx = ST_WAIT_RDY;
            ST_WAIT_RDY: if (i_ram_ready) state_nx = ST_STREAM;
            ST_STREAM:   if (issue && addr == LAST_ADDR) state_nx = ST_DRAIN;
            ST_DRAIN:    if (pop && o_last) state_nx = ST_DONE;
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state        <= ST_IDLE;
            addr         <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
            o_done       <= 1'b0;
        end else begin
            state        <= state_nx;
            inflight     <= issue;
            inflight_idx <= addr;
            o_done       <= (state == ST_DONE);
            if (accept)
                addr <= '0;
            else if (issue && addr != LAST_ADDR)
                addr <= addr + 1'b1;
        end
    end

    // The read issued last cycle lands now, tagged with its address.
    qkv_fetch_fifo #(.W(EW)) u_fifo (
        .s_clk (s_clk),
        .s_rst (s_rst),
        .push  (inflight),
        .pop   (pop),
        .din   ({i_q_line, i_k_line, i_v_line, inflight_idx}),
        .count (fifo_count),
        .head  (head)
    );

    assign {o_q_line, o_k_line, o_v_line, o_line_idx} = head;
    assign o_last    = o_valid && (o_line_idx == LAST_ADDR);
    assign o_rd_addr = addr;
    assign o_rd_en   = issue;
    assign o_busy    = (state == ST_WAIT_RDY) || (state == ST_STREAM) ||
                       (state == ST_DRAIN);

`ifdef QKV_FETCH_PERF_EN
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst)
            o_stall_cnt <= 16'd0;
        else if (accept)
            o_stall_cnt <= 16'd0;
        else if (o_valid && !i_ready && o_stall_cnt != 16'hFFFF)
            o_stall_cnt <= o_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_qkv_line_fetcher.sv
// Self-checking bench for qkv_line_fetcher: scoreboard of expected lines
// per pass, compared on every handshake; scenario tasks run in sequence.
module tb_qkv_line_fetcher;
    import qkv_line_fetcher_pkg::*;

    localparam int LW = QKV_LINE_W;
    localparam int AW = QKV_ADDR_W;
    localparam int NL = QKV_NUM_LINES;

    logic          s_clk = 1'b0;
    logic          s_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_ram_ready = 1'b0;
    logic [AW-1:0] o_rd_addr;
    logic          o_rd_en;
    logic [LW-1:0] q_line = '0;
    logic [LW-1:0] k_line = '0;
    logic [LW-1:0] v_line = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [LW-1:0] o_q_line;
    logic [LW-1:0] o_k_line;
    logic [LW-1:0] o_v_line;
    logic [AW-1:0] o_line_idx;
    logic          o_last;
    logic          o_busy;
    logic          o_done;
`ifdef QKV_FETCH_PERF_EN
    logic [15:0]   o_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int last_cyc = -1;
    int done_cyc = -1;
    bit mon_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [AW-1:0] prev_idx;
    logic [LW-1:0] prev_q;
    int sb[$];

    qkv_line_fetcher u_dut (
        .s_clk       (s_clk),
        .s_rst       (s_rst),
        .i_start     (i_start),
        .i_ram_ready (i_ram_ready),
        .o_rd_addr   (o_rd_addr),
        .o_rd_en     (o_rd_en),
        .i_q_line    (q_line),
        .i_k_line    (k_line),
        .i_v_line    (v_line),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_q_line    (o_q_line),
        .o_k_line    (o_k_line),
        .o_v_line    (o_v_line),
        .o_line_idx  (o_line_idx),
        .o_last      (o_last),
        .o_busy      (o_busy),
        .o_done      (o_done)
`ifdef QKV_FETCH_PERF_EN
        ,
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    always #5 s_clk = ~s_clk;

    always @(posedge s_clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] q_of(int n);
        return LW'(n) + LW'(1);
    endfunction
    function automatic logic [LW-1:0] k_of(int n);
        return (LW'(n) << 20) | LW'(2);
    endfunction
    function automatic logic [LW-1:0] v_of(int n);
        return (LW'(n) << 40) | LW'(3);
    endfunction

    // RAM group model: one-cycle read latency, data holds when not read.
    always @(posedge s_clk) begin
        if (o_rd_en) begin
            q_line <= q_of(int'(o_rd_addr));
            k_line <= k_of(int'(o_rd_addr));
            v_line <= v_of(int'(o_rd_addr));
        end
    end

    // Stream monitor: scoreboard pop on handshake, head stability, depth.
    always @(negedge s_clk) begin
        if (mon_en) begin
            checks++;
            if (u_dut.fifo_count > 2'd2) begin
                errors++;
                $display("FAIL fifo_depth count=%0d max=2", u_dut.fifo_count);
            end
            if (prev_stall) begin
                checks++;
                if (!o_valid || o_line_idx !== prev_idx || o_q_line !== prev_q) begin
                    errors++;
                    $display("FAIL head_stable valid=%0b idx=%0d expected idx=%0d",
                             o_valid, o_line_idx, prev_idx);
                end
            end
            if (o_valid && i_ready) begin
                hs_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL hs_extra idx=%0d expected no line", o_line_idx);
                end else begin
                    int e;
                    e = sb.pop_front();
                    if (o_line_idx !== AW'(e) || o_q_line !== q_of(e) ||
                        o_k_line !== k_of(e) || o_v_line !== v_of(e) ||
                        o_last !== (e == NL - 1)) begin
                        errors++;
                        $display("FAIL hs_line idx=%0d last=%0b expected idx=%0d last=%0b",
                                 o_line_idx, o_last, e, (e == NL - 1));
                    end
                    if (o_last) last_cyc = cyc;
                end
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = o_valid && !i_ready;
            prev_idx   = o_line_idx;
            prev_q     = o_q_line;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic new_pass();
        sb.delete();
        for (int n = 0; n < NL; n++) sb.push_back(n);
        hs_cnt = 0;
        done_cnt = 0;
        last_cyc = -1;
        done_cyc = -1;
        mon_en = 1'b1;
    endtask

    task automatic start_pass(output int c0);
        step();
        i_start = 1'b1;
        c0 = cyc;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        ok = (done_cnt != 0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        repeat (3) step();
        s_rst = 1'b0;
        @(negedge s_clk);
        checks++;
        if (o_rd_addr !== '0 || o_rd_en !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd addr=%0d en=%0b valid=%0b expected 0 0 0",
                     o_rd_addr, o_rd_en, o_valid);
        end
        checks++;
        if (o_line_idx !== '0 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_idx idx=%0d last=%0b expected 0 0", o_line_idx, o_last);
        end
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl busy=%0b done=%0b expected 0 0", o_busy, o_done);
        end
`ifdef QKV_FETCH_PERF_EN
        checks++;
        if (o_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall cnt=%0d expected 0", o_stall_cnt);
        end
`endif
    endtask

    task automatic test_basic();
        int c0, fv, fi;
        bit ok;
        i_ram_ready = 1'b1;
        i_ready = 1'b1;
        new_pass();
        start_pass(c0);
        @(negedge s_clk);
        checks++;
        if (o_busy !== 1'b1 || o_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait busy=%0b en=%0b expected 1 0", o_busy, o_rd_en);
        end
        fv = -1;
        fi = -1;
        for (int i = 0; i < 20 && fv < 0; i++) begin
            @(negedge s_clk);
            if (o_rd_en && fi < 0) fi = cyc - c0;
            if (o_valid) fv = cyc - c0;
        end
        checks++;
        if (fi != 2) begin
            errors++;
            $display("FAIL basic_first_issue cycle=%0d expected 2", fi);
        end
        checks++;
        if (fv != 4) begin
            errors++;
            $display("FAIL basic_first_valid cycle=%0d expected 4", fv);
        end
        wait_done(NL + 50, ok);
        checks++;
        if (!ok || hs_cnt != NL || sb.size() != 0) begin
            errors++;
            $display("FAIL basic_count done=%0b hs=%0d left=%0d expected 1 %0d 0",
                     ok, hs_cnt, sb.size(), NL);
        end
        checks++;
        if (last_cyc - c0 != 4 + NL - 1) begin
            errors++;
            $display("FAIL basic_last_cycle cycle=%0d expected %0d", last_cyc - c0, 4 + NL - 1);
        end
        checks++;
        if (done_cyc - last_cyc != 2) begin
            errors++;
            $display("FAIL basic_done_lat lat=%0d expected 2", done_cyc - last_cyc);
        end
        checks++;
        if (done_cnt != 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_once n=%0d busy=%0b expected 1 0", done_cnt, o_busy);
        end
        mon_en = 1'b0;
    endtask

    task automatic test_wait_ready();
        int c0, r, fv, bad;
        bit ok;
        i_ram_ready = 1'b0;
        i_ready = 1'b1;
        new_pass();
        start_pass(c0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge s_clk);
            if (o_rd_en || !o_busy || o_valid || u_dut.state != ST_WAIT_RDY) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait_hold bad_cycles=%0d expected 0", bad);
        end
        step();
        i_ram_ready = 1'b1;
        r = cyc;
        step();
        i_ram_ready = 1'b0;
        fv = -1;
        for (int i = 0; i < 20 && fv < 0; i++) begin
            @(negedge s_clk);
            if (o_valid) fv = cyc - r;
        end
        checks++;
        if (fv != 3) begin
            errors++;
            $display("FAIL wait_first_valid delay=%0d expected 3", fv);
        end
        wait_done(NL + 50, ok);
        checks++;
        if (!ok || hs_cnt != NL || done_cnt != 1) begin
            errors++;
            $display("FAIL wait_pass done=%0b hs=%0d pulses=%0d expected 1 %0d 1",
                     ok, hs_cnt, done_cnt, NL);
        end
        mon_en = 1'b0;
    endtask

    task automatic test_random_ready();
        int c0, n;
        i_ram_ready = 1'b1;
        i_ready = 1'b0;
        new_pass();
        start_pass(c0);
        n = 0;
        while (done_cnt == 0 && n < NL * 8) begin
            i_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        i_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (done_cnt != 1 || hs_cnt != NL || sb.size() != 0) begin
            errors++;
            $display("FAIL random_pass pulses=%0d hs=%0d left=%0d expected 1 %0d 0",
                     done_cnt, hs_cnt, sb.size(), NL);
        end
        mon_en = 1'b0;
    endtask

    task automatic test_back_pressure();
        int c0, bad;
        bit ok;
        i_ram_ready = 1'b1;
        i_ready = 1'b1;
        new_pass();
        start_pass(c0);
        while (cyc < c0 + 5) step();
        i_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge s_clk);
            if (i > 0) begin
                if (u_dut.fifo_count !== 2'd2 || o_rd_addr !== AW'(3) ||
                    o_rd_en !== 1'b0 || o_line_idx !== AW'(1) || !o_valid) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_freeze bad_cycles=%0d addr=%0d idx=%0d expected 0 3 1",
                     bad, o_rd_addr, o_line_idx);
        end
        step();
        i_ready = 1'b1;
        wait_done(NL + 80, ok);
        checks++;
        if (!ok || hs_cnt != NL) begin
            errors++;
            $display("FAIL stall_pass done=%0b hs=%0d expected 1 %0d", ok, hs_cnt, NL);
        end
`ifdef QKV_FETCH_PERF_EN
        checks++;
        if (o_stall_cnt !== 16'd20) begin
            errors++;
            $display("FAIL stall_cnt cnt=%0d expected 20", o_stall_cnt);
        end
`endif
        mon_en = 1'b0;
    endtask

    task automatic test_restart_reset();
        int c0, n;
        bit ok;
        i_ram_ready = 1'b1;
        i_ready = 1'b1;
        new_pass();
        start_pass(c0);
        while (cyc < c0 + 50) step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || u_dut.state != ST_STREAM) begin
            errors++;
            $display("FAIL restart_ignored busy=%0b state=%0d expected 1 %0d",
                     o_busy, u_dut.state, ST_STREAM);
        end
        n = 0;
        while (hs_cnt < 300 && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (hs_cnt < 300) begin
            errors++;
            $display("FAIL restart_progress hs=%0d expected 300", hs_cnt);
        end
        mon_en = 1'b0;
        s_rst = 1'b1;
        #2;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_rd_en !== 1'b0 ||
            o_rd_addr !== '0 || o_line_idx !== '0 || o_last !== 1'b0 ||
            o_done !== 1'b0 || u_dut.fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL abort_outputs valid=%0b busy=%0b en=%0b addr=%0d idx=%0d expected all 0",
                     o_valid, o_busy, o_rd_en, o_rd_addr, o_line_idx);
        end
        repeat (2) step();
        s_rst = 1'b0;
        step();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle done=%0b busy=%0b expected 0 0", o_done, o_busy);
        end
        new_pass();
        start_pass(c0);
        wait_done(NL + 50, ok);
        checks++;
        if (!ok || hs_cnt != NL || done_cnt != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL replay_pass done=%0b hs=%0d pulses=%0d expected 1 %0d 1",
                     ok, hs_cnt, done_cnt, NL);
        end
        mon_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wait_ready();
        test_random_ready();
        test_back_pressure();
        test_restart_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qkv_line_fetcher.md
# qkv_line_fetcher

- Downstream consumer of the Q/K/V spike-line RAM group.
- After a start pulse it waits for the RAM group's ready flag, then walks a single read address from 0 to NUM_LINES-1 across all three RAMs in lockstep.
- It absorbs the fixed 1-cycle BRAM read latency and presents matched {Q,K,V} spike lines as one valid/ready stream to the attention stage.
- A 2-entry credit-managed FIFO allows full-rate streaming under arbitrary backpressure without losing in-flight reads.

## Interface
Parameters:
- LINE_W, 128, spike-line width (2*SYSTOLIC_UNIT_NUM*TIME_STEPS)
- ADDR_W, 10, RAM address width
- NUM_LINES, 768, lines per pass
- FIFO_DEPTH, 2, output buffer entries (fixed at 2)

Ports:
- s_clk  in  1  clock
- s_rst  in  1  reset; asynchronous, active-high
- i_start  in  1  one-cycle start pulse; ignored while o_busy
- i_ram_ready  in  1  RAM group contents complete
- o_rd_addr  out  ADDR_W  read address, shared by the Q/K/V RAMs
- o_rd_en  out  1  read issued this cycle (debug/power)
- i_q_line, i_k_line, i_v_line  in  LINE_W  RAM read data, valid the cycle after issue
- o_valid  out  1  stream valid
- i_ready  in  1  stream ready from consumer
- o_q_line, o_k_line, o_v_line  out  LINE_W  FIFO head data
- o_line_idx  out  ADDR_W  index of the head line
- o_last  out  1  head is line NUM_LINES-1
- o_busy  out  1  pass in progress
- o_done  out  1  one-cycle pulse, pass complete
- o_stall_cnt  out  16  present only with QKV_FETCH_PERF_EN

## Operation
FSM states:
- IDLE: accepts i_start.
- WAIT_RDY: waits for i_ram_ready.
- STREAM: issues reads.
- DRAIN: waits for the FIFO to empty.
- DONE: pulses o_done.

Transitions:
- IDLE -> WAIT_RDY on i_start.
- WAIT_RDY -> STREAM when i_ram_ready is sampled high. If i_ram_ready is already high when i_start arrives, WAIT_RDY lasts exactly one cycle.
- STREAM -> DRAIN after the issue of address NUM_LINES-1.
- DRAIN -> DONE on the handshake of the line with o_last.
- DONE -> IDLE unconditionally.

Issue rule:
- Issue in STREAM iff (fifo_count + inflight - pop) < 2.
- pop = o_valid & i_ready.
- inflight = issued in the previous cycle. It is pushed to the FIFO at the end of the current cycle together with the issue-address index.
- o_rd_addr holds the issue counter and increments only on issue. It does not move while stalled.
- The counter stops at NUM_LINES-1; there is no wrap. It clears to 0 on entry to WAIT_RDY.

Other rules:
- Q, K and V are always read at the same address. Data is never mixed across lines.
- o_busy is high in WAIT_RDY, STREAM and DRAIN.
- i_start while busy is dropped and has no effect.
- If i_ram_ready falls during STREAM or DRAIN, the pass continues; readiness is sampled only in WAIT_RDY.
- Simultaneous push and pop: count unchanged, head advances.

## Timing
Reset values:
- o_rd_addr=0, o_rd_en=0, o_valid=0, o_line_idx=0, o_last=0, o_busy=0, o_done=0, o_stall_cnt=0.
- FIFO emptied, inflight=0, state IDLE.
- Data outputs are don't-care while o_valid=0.

Latency:
- i_start at cycle 0 (with ready high): WAIT_RDY in cycle 1, first issue in cycle 2, data in cycle 3, o_valid in cycle 4.

Throughput and handshake:
- Throughput is 1 line/cycle with i_ready held high.
- Last valid is at cycle 4+NUM_LINES-1; o_done follows 2 cycles after the last handshake (DRAIN -> DONE edge, then the pulse).
- o_valid never drops without a handshake, and head data stays stable while o_valid & !i_ready.
- A reset mid-pass aborts immediately to IDLE. No o_done is produced and FIFO contents are discarded.

## Configuration
QKV_FETCH_PERF_EN:
- Defined: o_stall_cnt exists. It counts cycles with o_valid & !i_ready during the pass, saturates at 16'hFFFF, clears on i_start acceptance, and holds after o_done.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
Shared package (hyper-parameter header):
- QKV_LINE_W, QKV_NUM_LINES, QKV_ADDR_W constants.
- FSM state encodings.

Sub-module qkv_fetch_fifo:
- 2-entry register FIFO of width 3*LINE_W+ADDR_W.
- Ports push, pop, count, head.
- The FSM, issue counter, credit logic and perf counter stay in the top module.

## Test plan
- Reset, start with i_ram_ready=1, i_ready=1, RAM model line n = {n,n,n} -> o_valid first at cycle 4; 768 consecutive handshakes with idx 0..767; o_last only on 767; o_done pulse once.
- i_ram_ready=0 for 100 cycles after start -> o_rd_en stays 0 and state stays WAIT_RDY; after ready rises, first o_valid arrives 3 cycles later.
- Random i_ready (50%) -> every idx 0..767 appears exactly once, in order, with matching Q/K/V data; fifo_count never exceeds 2.
- i_ready held low from cycle 5 for 20 cycles -> exactly 2 lines buffered, o_rd_addr frozen, head stable; with PERF_EN, o_stall_cnt=20.
- i_start re-pulsed mid-pass, then s_rst asserted at line 300 -> the second start is ignored; after reset all outputs are 0 and a new start replays from idx 0.
